// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory read data, pipeline control and
// redirect inputs, plus the PC and IF/ID outputs. The fetch unit is the
// slave; whatever drives control and memory data is the master.
interface pc_fetch_unit_if;
    logic [31:0] instruction;
    logic        stall;
    logic        halt;
    logic        redirect_en;
    logic [1:0]  redirect_sel;
    logic [31:0] redirect_base;
    logic [15:0] redirect_imm;
    logic [25:0] redirect_addr;
    logic [31:0] redirect_reg;
    logic [31:0] program_counter;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    modport master (
        output instruction, stall, halt, redirect_en, redirect_sel,
               redirect_base, redirect_imm, redirect_addr, redirect_reg,
        input  program_counter, ifid_instr, ifid_pc_plus1, ifid_valid,
               fetch_count
    );

    modport slave (
        input  instruction, stall, halt, redirect_en, redirect_sel,
               redirect_base, redirect_imm, redirect_addr, redirect_reg,
        output program_counter, ifid_instr, ifid_pc_plus1, ifid_valid,
               fetch_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: word-addressed PC, IF/ID pipeline register and
// fetch counter, sequenced by a BOOT -> RUN -> HALTED state machine.
// Priority in RUN is halt > redirect > stall > sequential fetch.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SEL_BRANCH   = 2'b00,
        SEL_JUMP     = 2'b01,
        SEL_JUMP_REG = 2'b10,
        SEL_RESERVED = 2'b11
    } redirect_sel_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus1;

    // Sequential successor; 32-bit add wraps 0xFFFF_FFFF to 0 naturally.
    assign pc_plus1 = pc_q + 32'd1;

    // Redirect target selection; the reserved encoding behaves as a branch.
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        redirect_target = bus.redirect_base
                        + {{16{bus.redirect_imm[15]}}, bus.redirect_imm};
        case (redirect_sel_e'(bus.redirect_sel))
            SEL_JUMP:     redirect_target = {bus.redirect_base[31:26], bus.redirect_addr};
            SEL_JUMP_REG: redirect_target = bus.redirect_reg;
            default:      redirect_target = bus.redirect_base
                                          + {{16{bus.redirect_imm[15]}}, bus.redirect_imm};
        endcase
    end

    // Next-state and datapath update for each FSM state.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_plus1_d = ifid_pc_plus1_q;
        ifid_valid_d    = ifid_valid_q;
        fetch_count_d   = fetch_count_q;

        case (state_q)
            BOOT: begin
                // One idle cycle at RESET_PC before the first fetch.
                state_d = RUN;
            end
            RUN: begin
                if (bus.halt) begin
                    // A concurrent redirect is dropped; the PC freezes here.
                    state_d      = HALTED;
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                end else if (bus.redirect_en) begin
                    // Squash the instruction being fetched; ifid_pc_plus1 keeps
                    // its last value and nothing is counted.
                    pc_d         = redirect_target;
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                end else if (!bus.stall) begin
                    pc_d            = pc_plus1;
                    ifid_instr_d    = bus.instruction;
                    ifid_pc_plus1_d = pc_plus1;
                    ifid_valid_d    = 1'b1;
                    fetch_count_d   = fetch_count_q + 32'd1;
                end
            end
            HALTED: begin
                // Only reset leaves this state; everything holds.
                state_d = HALTED;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q         <= BOOT;
            pc_q            <= RESET_PC;
            ifid_instr_q    <= 32'h0;
            ifid_pc_plus1_q <= 32'h0;
            ifid_valid_q    <= 1'b0;
            fetch_count_q   <= 32'h0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_plus1_q <= ifid_pc_plus1_d;
            ifid_valid_q    <= ifid_valid_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    // Outputs come straight from registers; no input reaches them combinationally.
    assign bus.program_counter = pc_q;
    assign bus.ifid_instr      = ifid_instr_q;
    assign bus.ifid_pc_plus1   = ifid_pc_plus1_q;
    assign bus.ifid_valid      = ifid_valid_q;
    assign bus.fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Instruction memory word k holds k+100.
// A second instance with RESET_PC = 0xFFFF_FFFF exercises PC wrap.
module tb_pc_fetch_unit;

    logic clk;
    logic rst;
    int   n_vectors;
    int   n_miscompares;

    pc_fetch_unit_if bus ();
    pc_fetch_unit_if bus_w ();

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    // Combinational instruction memory: word k = k + 100.
    assign bus.instruction   = bus.program_counter + 32'd100;
    assign bus_w.instruction = bus_w.program_counter + 32'd100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vectors++;
        if (got !== want) begin
            n_miscompares++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic expect_main(input string tag, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [31:0] plus1,
                               input logic valid, input logic [31:0] count);
        check({tag, ".pc"},    bus.program_counter, pc);
        check({tag, ".instr"}, bus.ifid_instr, instr);
        check({tag, ".plus1"}, bus.ifid_pc_plus1, plus1);
        check({tag, ".valid"}, {31'h0, bus.ifid_valid}, {31'h0, valid});
        check({tag, ".count"}, bus.fetch_count, count);
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        bus.stall       = 1'b0;
        bus.halt        = 1'b0;
        bus.redirect_en = 1'b0;
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst = 1'b1;
        clear_ctrl();
        bus.redirect_sel  = 2'b00;
        bus.redirect_base = 32'h0;
        bus.redirect_imm  = 16'h0;
        bus.redirect_addr = 26'h0;
        bus.redirect_reg  = 32'h0;
        bus_w.stall         = 1'b0;
        bus_w.halt          = 1'b0;
        bus_w.redirect_en   = 1'b0;
        bus_w.redirect_sel  = 2'b00;
        bus_w.redirect_base = 32'h0;
        bus_w.redirect_imm  = 16'h0;
        bus_w.redirect_addr = 26'h0;
        bus_w.redirect_reg  = 32'h0;

        // Reset state.
        step();
        step();
        expect_main("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("wrap_reset.pc", bus_w.program_counter, 32'hFFFF_FFFF);

        // BOOT cycle, then sequential fetch.
        rst = 1'b0;
        step();
        expect_main("boot", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        check("wrap_boot.pc", bus_w.program_counter, 32'hFFFF_FFFF);
        step();
        expect_main("seq1", 32'd1, 32'd100, 32'd1, 1'b1, 32'd1);
        check("wrap.pc",    bus_w.program_counter, 32'h0);
        check("wrap.plus1", bus_w.ifid_pc_plus1, 32'h0);
        check("wrap.instr", bus_w.ifid_instr, 32'd99);
        step();
        expect_main("seq2", 32'd2, 32'd101, 32'd2, 1'b1, 32'd2);
        step();
        expect_main("seq3", 32'd3, 32'd102, 32'd3, 1'b1, 32'd3);
        step();
        step();
        expect_main("seq5", 32'd5, 32'd104, 32'd5, 1'b1, 32'd5);

        // Two-cycle stall at pc=5.
        bus.stall = 1'b1;
        step();
        expect_main("stall1", 32'd5, 32'd104, 32'd5, 1'b1, 32'd5);
        step();
        expect_main("stall2", 32'd5, 32'd104, 32'd5, 1'b1, 32'd5);
        bus.stall = 1'b0;
        step();
        expect_main("resume", 32'd6, 32'd105, 32'd6, 1'b1, 32'd6);

        // Backward branch 10 + (-4) with a simultaneous stall.
        bus.stall         = 1'b1;
        bus.redirect_en   = 1'b1;
        bus.redirect_sel  = 2'b00;
        bus.redirect_base = 32'd10;
        bus.redirect_imm  = 16'hFFFC;
        step();
        expect_main("branch", 32'd6, 32'h0, 32'd6, 1'b0, 32'd6);
        clear_ctrl();
        step();
        expect_main("post_branch", 32'd7, 32'd106, 32'd7, 1'b1, 32'd7);

        // Jump keeps the upper 6 bits of the base.
        bus.redirect_en   = 1'b1;
        bus.redirect_sel  = 2'b01;
        bus.redirect_base = 32'hFC00_0001;
        bus.redirect_addr = 26'h3;
        step();
        expect_main("jump", 32'hFC00_0003, 32'h0, 32'd7, 1'b0, 32'd7);
        clear_ctrl();
        step();
        expect_main("post_jump", 32'hFC00_0004, 32'hFC00_0067, 32'hFC00_0004, 1'b1, 32'd8);

        // Jump-register.
        bus.redirect_en  = 1'b1;
        bus.redirect_sel = 2'b10;
        bus.redirect_reg = 32'h40;
        step();
        expect_main("jr", 32'h40, 32'h0, 32'hFC00_0004, 1'b0, 32'd8);
        clear_ctrl();
        step();
        expect_main("post_jr", 32'h41, 32'hA4, 32'h41, 1'b1, 32'd9);

        // Reserved select behaves as a forward branch: 0x20 + 5.
        bus.redirect_en   = 1'b1;
        bus.redirect_sel  = 2'b11;
        bus.redirect_base = 32'h20;
        bus.redirect_imm  = 16'h0005;
        step();
        expect_main("sel11", 32'h25, 32'h0, 32'h41, 1'b0, 32'd9);
        clear_ctrl();
        step();
        expect_main("post_sel11", 32'h26, 32'h89, 32'h26, 1'b1, 32'd10);

        // Halt beats a simultaneous redirect and stall.
        bus.halt         = 1'b1;
        bus.redirect_en  = 1'b1;
        bus.stall        = 1'b1;
        bus.redirect_sel = 2'b10;
        bus.redirect_reg = 32'h999;
        step();
        expect_main("halt", 32'h26, 32'h0, 32'h26, 1'b0, 32'd10);

        // HALTED ignores all control inputs.
        for (int i = 0; i < 5; i++) begin
            bus.halt         = 1'b0;
            bus.redirect_en  = (i % 2) == 0;
            bus.stall        = (i % 2) == 1;
            bus.redirect_sel = 2'(i);
            bus.redirect_reg = 32'h1000 + 32'(i);
            step();
            expect_main($sformatf("halted%0d", i), 32'h26, 32'h0, 32'h26, 1'b0, 32'd10);
        end

        // Reset from HALTED with stall/redirect active; it must wait for the edge.
        rst             = 1'b1;
        bus.stall       = 1'b1;
        bus.redirect_en = 1'b1;
        #2;
        check("rst_sync.pc", bus.program_counter, 32'h26);
        step();
        expect_main("rst_halted", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        clear_ctrl();
        step();
        expect_main("reboot", 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();
        expect_main("refetch", 32'd1, 32'd100, 32'd1, 1'b1, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
